div: RTL
========

Name: div

Overview:
- Multi-cycle 32-bit integer divider; sits beside the execute stage.
- Consumes the execute stage's divide request: operands, start and signed flag.
- Returns the 64-bit {remainder, quotient} and a ready flag; execute writes these to HI/LO.
- Restoring shift/subtract algorithm, one quotient bit per cycle; execute holds a pipeline stall until ready.

Parameters:
- None. Widths come from shared `RegBus` (32) and `DoubleRegBus` (64).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset. Synchronous, active-high (`RstEnable` = 1'b1).
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  `DivStart` = request, `DivStop` = release; held by execute for the whole operation.
- annul_i  in  1  1 = cancel the division in progress (flush/exception).
- result_o  out  64  [63:32] remainder, [31:0] quotient; registered.
- ready_o  out  1  `DivResultReady` / `DivResultNotReady`; registered.

Behaviour:
- Reset (sync) values: state=DivFree, cnt=0, result_o=0, ready_o=`DivResultNotReady`.
  - Reset mid-operation aborts immediately; no partial result is ever presented.
- Internal state:
  - 2-bit state register; 6-bit cnt.
  - 65-bit work register dw: upper half = partial remainder, lower half = quotient shifting in.
  - 32-bit divisor register; latched operand signs.
- DivFree:
  - start_i=DivStart and annul_i=0, divisor==0: go to DivByZero.
  - start_i=DivStart and annul_i=0, divisor!=0:
    - Latch abs(op1) and abs(op2); abs() applies only when signed_div_i=1 and bit31=1, computed as ~x+1.
    - dw={32'b0, abs(op1), 1'b0}; cnt=0; go to DivOn.
  - Otherwise stay; outputs remain 0/NotReady.
- DivByZero: dw=0; go to DivEnd next edge.
- DivOn:
  - annul_i=1: go to DivFree, cnt=0, outputs 0. Takes priority over iteration.
  - cnt!=32, one iteration:
    - t = {1'b0, dw[63:32]} - {1'b0, divisor}.
    - t[32]=1: dw = dw<<1.
    - t[32]=0: dw = {t[31:0], dw[31:0], 1'b1}.
    - cnt++.
  - cnt==32, correction cycle:
    - Quotient dw[31:0] is negated if signed and op1 sign != op2 sign.
    - Remainder dw[64:33] is negated if signed and op1 negative (remainder takes the dividend's sign).
    - Load result_o={rem, quot}; ready_o=Ready; cnt=0; go to DivEnd.
- DivEnd:
  - Hold result_o and ready_o stable while start_i=DivStart. annul_i is ignored here.
  - start_i=DivStop: clear result_o=0, ready_o=NotReady; go to DivFree.
- Latency, counted from edge E0 that samples start:
  - E1..E32 are iterations.
  - ready_o is high after E33: 33 edges, 34 cycles including the request cycle.
  - Divide-by-zero: ready_o high after E2, result 0.
- Operands are sampled only at E0; later operand changes are ignored.
- INT_MIN handling: abs(0x80000000) = 0x80000000 treated as unsigned 2^31, so no overflow inside the datapath.
- Back-to-back requests: a new start is only accepted from DivFree, so at least one DivStop cycle is required between operations.

Decomposition:
- Shared defines file, extended with:
  - state encodings DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11;
  - DivResultReady 1'b1, DivResultNotReady 1'b0, DivStart 1'b1, DivStop 1'b0.
- Already present and reused: RstEnable, ZeroWord, RegBus, DoubleRegBus.
- No sub-module. A single always block plus a continuous-assign trial subtractor is natural at about 150 lines.

Test Plan:
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002): ready after E33; result_o = {0xFFFFFFFF, 0xFFFFFFFD} (r=-1, q=-3).
- Unsigned 0xFFFFFFFF / 0x00000010: result_o = {0x0000000F, 0x0FFFFFFF}. The same operands signed give {0xFFFFFFFF, 0x00000000}.
- Signed 7 / -2: {0x00000001, 0xFFFFFFFD}. Signed 0x80000000 / 0xFFFFFFFF: {0x00000000, 0x80000000}.
- Divisor 0 (any dividend): ready after E2; result_o = 0. Then DivStop gives ready 0 and state DivFree within 1 edge.
- annul_i pulsed at cnt=10: back in DivFree next edge, ready never rises. A fresh 100/7 request then yields {2, 14} on schedule.
- rst asserted mid-DivOn, and separately in DivEnd with start held: outputs 0/NotReady after that edge. After reset, a subsequent request completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, reset level and divider encodings
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic                  RstEnable  = 1'b1;
  localparam logic [RegBus-1:0]     ZeroWord   = 32'h0000_0000;
  localparam logic [DoubleRegBus-1:0] ZeroDword = 64'h0;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [5:0] DivSteps = 6'd32;

endpackage

// File: rtl/div.sv
// rtl/div.sv - multi-cycle restoring 32-bit divider, one quotient bit per cycle
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  logic [1:0]        state;
  logic [5:0]        cnt;
  logic [64:0]       dw;
  logic [RegBus-1:0] divisor;
  logic              op1_neg;
  logic              op2_neg;

  logic [RegBus:0]   trial;
  logic [RegBus-1:0] op1_abs;
  logic [RegBus-1:0] op2_abs;
  logic [RegBus-1:0] quot_fix;
  logic [RegBus-1:0] rem_fix;

  // Trial subtraction of the divisor from the current partial remainder;
  // bit 32 set means the divisor did not fit and the step restores.
  assign trial = {1'b0, dw[63:32]} - {1'b0, divisor};

  // Magnitudes of the operands; INT_MIN maps onto itself and is read as 2^31.
  assign op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Sign correction: quotient negative when signs differ, remainder follows the dividend.
  assign quot_fix = (op1_neg ^ op2_neg) ? (~dw[31:0] + 32'd1) : dw[31:0];
  assign rem_fix  = op1_neg ? (~dw[64:33] + 32'd1) : dw[64:33];

  // Divider control and datapath: accept, iterate, correct, then hold until released.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= DivFree;
      cnt      <= 6'd0;
      dw       <= 65'd0;
      divisor  <= ZeroWord;
      op1_neg  <= 1'b0;
      op2_neg  <= 1'b0;
      result_o <= ZeroDword;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          result_o <= ZeroDword;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == ZeroWord) begin
              state <= DivByZero;
            end else begin
              state   <= DivOn;
              cnt     <= 6'd0;
              dw      <= {32'b0, op1_abs, 1'b0};
              divisor <= op2_abs;
              op1_neg <= signed_div_i & opdata1_i[31];
              op2_neg <= signed_div_i & opdata2_i[31];
            end
          end
        end

        DivByZero: begin
          dw    <= 65'd0;
          state <= DivEnd;
        end

        DivOn: begin
          if (annul_i) begin
            state    <= DivFree;
            cnt      <= 6'd0;
            result_o <= ZeroDword;
            ready_o  <= DivResultNotReady;
          end else if (cnt != DivSteps) begin
            if (trial[32]) begin
              dw <= {dw[63:0], 1'b0};
            end else begin
              dw <= {trial[31:0], dw[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            // Corrected values are written back so DivEnd can keep reloading them.
            dw       <= {rem_fix, 1'b0, quot_fix};
            result_o <= {rem_fix, quot_fix};
            ready_o  <= DivResultReady;
            cnt      <= 6'd0;
            state    <= DivEnd;
          end
        end

        DivEnd: begin
          if (start_i == DivStart) begin
            result_o <= {dw[64:33], dw[31:0]};
            ready_o  <= DivResultReady;
          end else begin
            result_o <= ZeroDword;
            ready_o  <= DivResultNotReady;
            state    <= DivFree;
          end
        end

        default: begin
          state <= DivFree;
        end
      endcase
    end
  end

endmodule
